run_watch_ctrl: RTL and testbench

RUN_WATCH_CTRL -- requirements
Module: run_watch_ctrl

---
 rtl/run_watch_pkg.sv | 21 ++
 rtl/key_debounce.sv | 61 ++++++
 rtl/run_watch_ctrl.sv | 109 ++++++++++
 tb/tb_run_watch_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/run_watch_pkg.sv
// Shared definitions for the run/lap stopwatch controller.
//   run_state_t : FSM state encoding (IDLE=0, RUN=1, LAP=2, STOP=3)
//   LAP_MAX     : saturation value of the lap counter
//   deb_cycles  : debounce window in clock cycles from clock rate and window in ms
package run_watch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAP  = 2'd2,
        STOP = 2'd3
    } run_state_t;

    localparam logic [3:0] LAP_MAX = 4'd15;

    function automatic int unsigned deb_cycles(input int unsigned clk_hz,
                                               input int unsigned deb_ms);
        return (clk_hz / 1000) * deb_ms;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronizer + debouncer for one active-low mechanical key.
//   cp     : system clock (rising edge)
//   reset  : synchronous active-high reset
//   key_n  : raw key, active-low, asynchronous to cp
//   press  : one-cycle pulse when the debounced level goes 1 -> 0
module key_debounce #(
    parameter int unsigned DEB_CYC = 10
) (
    input  logic cp,
    input  logic reset,
    input  logic key_n,
    output logic press
);

    localparam int unsigned   CW       = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYC - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          armed;
    logic [1:0]    settle;
    logic [CW-1:0] cnt;

    // The synchronizer is forced released during reset, so its output only
    // reflects the real key two edges after release (settle[1]). A press is
    // only reported once the key has been seen released after reset, which
    // suppresses a pulse for a key held across reset release.
    always_ff @(posedge cp) begin
        if (reset) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            armed  <= 1'b0;
            settle <= '0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1  <= key_n;
            sync2  <= sync1;
            settle <= {settle[0], 1'b1};
            press  <= 1'b0;
            if (settle[1] && sync2) begin
                armed <= 1'b1;
            end
            if (sync2 != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= sync2;
                    cnt    <= '0;
                    // stable is still 1 here only on a 1 -> 0 change
                    press  <= stable & armed;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/run_watch_ctrl.sv
// Stopwatch run/lap/stop control FSM driving a BCD counter chain.
//   cp       : system clock (rising edge)
//   reset    : synchronous active-high reset (also clears the counter chain)
//   key_ss   : raw start/stop key, active-low
//   key_lap  : raw lap/clear key, active-low
//   cnt_en   : count enable (RUN or LAP)
//   cnt_clr  : one-cycle clear pulse (STOP -> IDLE), held high during reset
//   lap_hold : display freeze while in LAP
//   lap_cnt  : laps taken since last clear, saturating at 15
//   state    : current FSM state
module run_watch_ctrl
    import run_watch_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned DEB_MS = 20
) (
    input  logic       cp,
    input  logic       reset,
    input  logic       key_ss,
    input  logic       key_lap,
    output logic       cnt_en,
    output logic       cnt_clr,
    output logic       lap_hold,
    output logic [3:0] lap_cnt,
    output logic [1:0] state
);

    localparam int unsigned DEB_CYC = deb_cycles(CLK_HZ, DEB_MS);

    logic       ss_press;
    logic       lap_press;
    run_state_t state_q;
    run_state_t state_d;
    logic       en_d;
    logic       hold_d;
    logic       clr_d;
    logic [3:0] cnt_d;

    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_ss (
        .cp    (cp),
        .reset (reset),
        .key_n (key_ss),
        .press (ss_press)
    );

    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_lap (
        .cp    (cp),
        .reset (reset),
        .key_n (key_lap),
        .press (lap_press)
    );

    // ss is tested first in every state so it wins over a coincident lap.
    always_comb begin
        state_d = state_q;
        cnt_d   = lap_cnt;
        clr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_press) state_d = RUN;
            end
            RUN: begin
                if (ss_press) begin
                    state_d = STOP;
                end else if (lap_press) begin
                    state_d = LAP;
                    if (lap_cnt != LAP_MAX) cnt_d = lap_cnt + 4'd1;
                end
            end
            LAP: begin
                if (ss_press)       state_d = STOP;
                else if (lap_press) state_d = RUN;
            end
            STOP: begin
                if (ss_press) begin
                    state_d = RUN;
                end else if (lap_press) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Outputs are decoded from the next state so the registered copies
        // change on the same edge as the state register.
        en_d   = (state_d == RUN) || (state_d == LAP);
        hold_d = (state_d == LAP);
    end

    always_ff @(posedge cp) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_en   <= 1'b0;
            lap_hold <= 1'b0;
            lap_cnt  <= '0;
            cnt_clr  <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_en   <= en_d;
            lap_hold <= hold_d;
            lap_cnt  <= cnt_d;
            cnt_clr  <= clr_d;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_run_watch_ctrl.sv
// Scoreboard bench for run_watch_ctrl with CLK_HZ=10_000, DEB_MS=1 (DEB_CYC=10).
// Stimulus pushes the expected state/outputs of each transition into a queue;
// a negedge monitor pops and compares whenever the DUT state changes.
module tb_run_watch_ctrl;

    logic       cp = 1'b0;
    logic       reset;
    logic       key_ss;
    logic       key_lap;
    logic       cnt_en;
    logic       cnt_clr;
    logic       lap_hold;
    logic [3:0] lap_cnt;
    logic [1:0] state;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0] st;
        logic       en;
        logic       hold;
        logic [3:0] cnt;
    } exp_t;

    exp_t       exp_q[$];
    bit         mon_on = 1'b0;
    logic [1:0] prev_st;

    run_watch_ctrl #(
        .CLK_HZ (10_000),
        .DEB_MS (1)
    ) dut (
        .cp       (cp),
        .reset    (reset),
        .key_ss   (key_ss),
        .key_lap  (key_lap),
        .cnt_en   (cnt_en),
        .cnt_clr  (cnt_clr),
        .lap_hold (lap_hold),
        .lap_cnt  (lap_cnt),
        .state    (state)
    );

    always #5 cp = ~cp;

    task automatic chk(input string name, input bit ok, input int act, input int req);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge cp);
        #1;
    endtask

    task automatic expect_st(input logic [1:0] st, input logic [3:0] cnt);
        exp_t e;
        e.st   = st;
        e.en   = (st == 2'd1) || (st == 2'd2);
        e.hold = (st == 2'd2);
        e.cnt  = cnt;
        exp_q.push_back(e);
    endtask

    // Press the selected key(s) for 20 cycles, then release and let the
    // release debounce out. Latency to a state change must be 13 +/- 1.
    task automatic press(input bit s, input bit l, input bit expect_change);
        logic [1:0] from;
        int n;
        from = state;
        if (s) key_ss  = 1'b0;
        if (l) key_lap = 1'b0;
        n = 0;
        while (state == from && n < 30) begin
            tick(1);
            n++;
        end
        if (expect_change)
            chk("press_latency", n >= 12 && n <= 14, n, 13);
        else
            chk("no_state_change", state == from, state, from);
        if (n < 20) tick(20 - n);
        key_ss  = 1'b1;
        key_lap = 1'b1;
        tick(16);
    endtask

    always @(negedge cp) begin
        exp_t e;
        if (mon_on) begin
            chk("cnt_en_vs_state", cnt_en == (state == 2'd1 || state == 2'd2), cnt_en,
                (state == 2'd1 || state == 2'd2));
            chk("lap_hold_vs_state", lap_hold == (state == 2'd2), lap_hold, (state == 2'd2));
            chk("cnt_clr_only_idle", !cnt_clr || state == 2'd0, state, 0);
            if (state !== prev_st) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_transition", 1'b0, state, prev_st);
                end else begin
                    e = exp_q.pop_front();
                    chk("tr_state",    state    == e.st,   state,    e.st);
                    chk("tr_cnt_en",   cnt_en   == e.en,   cnt_en,   e.en);
                    chk("tr_lap_hold", lap_hold == e.hold, lap_hold, e.hold);
                    chk("tr_lap_cnt",  lap_cnt  == e.cnt,  lap_cnt,  e.cnt);
                end
                prev_st = state;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int entries;
        reset   = 1'b1;
        key_ss  = 1'b1;
        key_lap = 1'b1;
        tick(3);
        chk("rst_state",    state == 2'd0,    state,    0);
        chk("rst_cnt_en",   cnt_en == 1'b0,   cnt_en,   0);
        chk("rst_lap_hold", lap_hold == 1'b0, lap_hold, 0);
        chk("rst_lap_cnt",  lap_cnt == 4'd0,  lap_cnt,  0);
        chk("rst_cnt_clr",  cnt_clr == 1'b1,  cnt_clr,  1);
        reset = 1'b0;
        tick(1);
        chk("post_rst_cnt_clr", cnt_clr == 1'b0, cnt_clr, 0);
        prev_st = state;
        mon_on  = 1'b1;

        // lap is ignored in IDLE
        press(1'b0, 1'b1, 1'b0);

        // basic start
        expect_st(2'd1, 4'd0);
        press(1'b1, 1'b0, 1'b1);

        // bouncing ss (4-cycle toggles), then a clean hold: RUN -> STOP
        expect_st(2'd3, 4'd0);
        for (int i = 0; i < 10; i++) begin
            key_ss = ~key_ss;
            tick(4);
        end
        chk("bounce_no_change", state == 2'd1, state, 1);
        press(1'b1, 1'b0, 1'b1);

        // resume
        expect_st(2'd1, 4'd0);
        press(1'b1, 1'b0, 1'b1);

        // lap sequence
        expect_st(2'd2, 4'd1); press(1'b0, 1'b1, 1'b1);
        expect_st(2'd1, 4'd1); press(1'b0, 1'b1, 1'b1);
        expect_st(2'd2, 4'd2); press(1'b0, 1'b1, 1'b1);
        chk("lap_cnt_two", lap_cnt == 4'd2, lap_cnt, 2);

        // ss from LAP -> STOP
        expect_st(2'd3, 4'd2);
        press(1'b1, 1'b0, 1'b1);
        chk("stop_cnt_en", cnt_en == 1'b0, cnt_en, 0);

        // clear from STOP: cnt_clr exactly one cycle
        expect_st(2'd0, 4'd0);
        key_lap = 1'b0;
        n = 0;
        while (state == 2'd3 && n < 30) begin
            tick(1);
            n++;
        end
        chk("clear_latency", n >= 12 && n <= 14, n, 13);
        chk("clear_pulse_high", cnt_clr == 1'b1, cnt_clr, 1);
        chk("clear_lap_cnt", lap_cnt == 4'd0, lap_cnt, 0);
        tick(1);
        chk("clear_pulse_one_cycle", cnt_clr == 1'b0, cnt_clr, 0);
        if (n < 19) tick(19 - n);
        key_lap = 1'b1;
        tick(16);

        // simultaneous ss + lap in RUN: ss wins, lap_cnt untouched
        expect_st(2'd1, 4'd0); press(1'b1, 1'b0, 1'b1);
        expect_st(2'd2, 4'd1); press(1'b0, 1'b1, 1'b1);
        expect_st(2'd1, 4'd1); press(1'b0, 1'b1, 1'b1);
        expect_st(2'd3, 4'd1); press(1'b1, 1'b1, 1'b1);
        chk("simul_lap_cnt", lap_cnt == 4'd1, lap_cnt, 1);

        // clear, restart, then 17 lap entries to saturate
        expect_st(2'd0, 4'd0); press(1'b0, 1'b1, 1'b1);
        expect_st(2'd1, 4'd0); press(1'b1, 1'b0, 1'b1);
        for (int k = 1; k <= 33; k++) begin
            entries = (k + 1) / 2;
            if (entries > 15) entries = 15;
            expect_st((k % 2 == 1) ? 2'd2 : 2'd1, 4'(entries));
            press(1'b0, 1'b1, 1'b1);
        end
        chk("sat_lap_cnt", lap_cnt == 4'd15, lap_cnt, 15);
        chk("sat_state_lap", state == 2'd2, state, 2);

        // one-cycle reset mid-LAP with ss held across release
        expect_st(2'd0, 4'd0);
        key_ss = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("midrst_state",    state == 2'd0,    state,    0);
        chk("midrst_cnt_en",   cnt_en == 1'b0,   cnt_en,   0);
        chk("midrst_lap_hold", lap_hold == 1'b0, lap_hold, 0);
        chk("midrst_lap_cnt",  lap_cnt == 4'd0,  lap_cnt,  0);
        chk("midrst_cnt_clr",  cnt_clr == 1'b1,  cnt_clr,  1);
        reset = 1'b0;
        tick(1);
        chk("midrst_clr_drop", cnt_clr == 1'b0, cnt_clr, 0);
        tick(40);
        key_ss = 1'b1;
        tick(16);
        chk("held_key_no_pulse", state == 2'd0, state, 0);

        // a fresh press works again
        expect_st(2'd1, 4'd0);
        press(1'b1, 1'b0, 1'b1);

        tick(2);
        chk("scoreboard_drained", exp_q.size() == 0, exp_q.size(), 0);
        mon_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
